instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 start  input  1  one-cycle pulse that begins a load job; ignored outside IDLE.
REQ-004 base_addr  input  32  first imem word address of the job, sampled on start.
REQ-005 count  input  16  number of input requests in the job, sampled on start.
REQ-006 in_valid/in_ready  input/output  1/1  request handshake; transfer when both are high.
REQ-007 in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm  input  7/5/5/5/3/7/32  instruction fields; in_imm is the full signed or upper value.
REQ-008 out_valid/out_ready  output/input  1/1  imem write handshake.
REQ-009 out_instr, out_addr  output  32/32  encoded word and its imem address.
REQ-010 err_pulse  output  1  one-cycle flag for a rejected request.
REQ-011 err_count  output  8  saturating count of rejected requests.
REQ-012 busy, done  output  1/1  busy is high when not in IDLE; done is a one-cycle completion pulse.

Function
REQ-013 FSM states: IDLE, LOAD, DRAIN, DONE.
- IDLE --start--> LOAD, or DONE when count==0.
- LOAD --last request accepted--> DRAIN.
- DRAIN --output register empty--> DONE.
- DONE --> IDLE after one cycle, with done=1 in that cycle.
REQ-014 in_ready = (state==LOAD) && (!out_valid || out_ready); in_ready is 0 in every other state.
REQ-015 Every accepted request decrements the remaining count, whether the request is encoded or rejected.
REQ-016 Latency is one cycle: an accepted valid encoding appears on out_instr/out_addr with out_valid=1 in the next cycle.
REQ-017 While out_valid=1 and out_ready=0, out_instr, out_addr and out_valid hold stable.
REQ-018 out_valid clears after the transfer unless a new encoding is loaded in the same cycle; back-to-back throughput is 1 word per cycle.
REQ-019 out_addr starts at base_addr and increments by 4 after each encoded word; it wraps modulo 2^32; rejected requests do not advance it.
REQ-020 I-type encoding (opcodes 0010011, 0000011, 1100111): {imm[11:0], rs1, funct3, rd, opcode}.
REQ-021 S-type encoding (0100011): {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
REQ-022 B-type encoding (1100011): {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
REQ-023 J-type encoding (1101111): {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
REQ-024 U-type encoding (0110111, 0010111): {imm[31:12], rd, opcode}.
REQ-025 R-type encoding (0110011): {funct7, rs2, rs1, funct3, rd, opcode}.
REQ-026 An unknown opcode is rejected: err_pulse=1 in the cycle after acceptance and no output word is produced.
REQ-027 err_count increments on each rejection and saturates at 255; it clears only on reset.
REQ-028 If start arrives outside IDLE, it is ignored and has no side effects.

Reset
REQ-029 On rst=1, asynchronously: state=IDLE; out_valid=0; out_instr=0; out_addr=0; err_pulse=0; err_count=0; done=0; busy=0; in_ready=0; remaining count=0.
REQ-030 Reset asserted mid-job abandons the job: the pending output word is discarded and no done pulse is produced.

Configuration
REQ-031 Macro IMM_RANGE_CHECK_EN.
- Defined: a request is rejected (per REQ-026/027) when its immediate does not fit the format:
  - I/S: imm outside [-2048, 2047].
  - B: imm outside [-4096, 4094], or imm[0]=1.
  - J: imm outside [-1048576, 1048574], or imm[0]=1.
  - U: imm[11:0] != 0.
- Undefined: the immediate is truncated to the format bits with no check, imm[0] is ignored for B/J, and only unknown opcodes are rejected.

Verification
REQ-032 start, base_addr=0x100, count=1; addi (opcode 0010011, rd=1, rs1=0, funct3=0, imm=5) -> out_instr=0x00500093, out_addr=0x100, then done pulse.
REQ-033 Back-to-back with out_ready=1: sw (rs1=1, rs2=2, funct3=010, imm=8), then jal (rd=1, imm=8), then lui (rd=5, imm=0x12345000) -> out_instr 0x0020A423, 0x008000EF, 0x123452B7 at addresses base, base+4, base+8 on consecutive cycles.
REQ-034 With macro defined: addi imm=4096 -> err_pulse=1, err_count=1, no out_valid, next word written at the unadvanced address.
REQ-035 out_ready held 0 for 5 cycles with a word pending -> out_instr/out_addr stable, in_ready=0; on release, exactly one transfer occurs.
REQ-036 start with count=0 -> done pulse within 2 cycles and no output; rst asserted mid-LOAD -> all outputs reach reset values immediately.

Source files
------------

// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
//   Loads a job of decoded RV32 instruction requests, encodes each one into a
//   32-bit instruction word and presents it for writing to consecutive imem
//   word addresses starting at base_addr. Requests with an unknown opcode are
//   rejected (counted, flagged, no word written).
//
// Ports
//   clk, rst              clock; asynchronous active-high reset
//   start                 one-cycle job start pulse (honoured only in IDLE)
//   base_addr, count      job start address / number of requests, sampled on start
//   in_valid, in_ready    request handshake
//   in_opcode .. in_imm   instruction fields (in_imm is the full immediate value)
//   out_valid, out_ready  imem write handshake
//   out_instr, out_addr   encoded word and its imem address
//   err_pulse, err_count  one-cycle reject flag / saturating reject count
//   busy, done            not-IDLE indicator / one-cycle job completion pulse
//
// Build option
//   IMM_RANGE_CHECK_EN    when defined, requests whose immediate does not fit
//                         the encoding format (or is misaligned for B/J, or
//                         has nonzero low bits for U) are rejected as well.
//                         When undefined, immediates are truncated silently.
// -----------------------------------------------------------------------------
module instr_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic [15:0] count,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  in_opcode,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        err_pulse,
  output logic [7:0]  err_count,
  output logic        busy,
  output logic        done
);

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned ERR_W  = 8;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e             state_q,     state_d;
  logic [CNT_W-1:0]   remaining_q, remaining_d;
  logic [ADDR_W-1:0]  addr_ptr_q,  addr_ptr_d;
  logic               out_valid_q, out_valid_d;
  logic [WORD_W-1:0]  out_instr_q, out_instr_d;
  logic [ADDR_W-1:0]  out_addr_q,  out_addr_d;
  logic               err_pulse_q, err_pulse_d;
  logic [ERR_W-1:0]   err_count_q, err_count_d;
  logic               busy_q,      busy_d;
  logic               done_q,      done_d;

  logic               accept;
  logic [WORD_W-1:0]  enc_word;
  logic               enc_ok;

`ifdef IMM_RANGE_CHECK_EN
  // True when v is representable as an n-bit two's-complement value.
  function automatic logic fits_signed(input logic [31:0] v, input int unsigned n);
    logic [31:0] hi;
    hi = 32'($signed(v) >>> (n - 1));
    return (hi == '0) || (hi == '1);
  endfunction
`endif

  // The output register may be refilled in the same cycle it is drained.
  assign in_ready = (state_q == S_LOAD) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  // Field packing per instruction format; enc_ok=0 marks a rejected request.
  always_comb begin : encode
    enc_word = '0;
    enc_ok   = 1'b1;
    case (in_opcode)
      OP_IMM, OP_LOAD, OP_JALR: begin
        enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
`ifdef IMM_RANGE_CHECK_EN
        enc_ok = fits_signed(in_imm, 12);
`endif
      end
      OP_STORE: begin
        enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
`ifdef IMM_RANGE_CHECK_EN
        enc_ok = fits_signed(in_imm, 12);
`endif
      end
      OP_BRANCH: begin
        enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                    in_imm[4:1], in_imm[11], in_opcode};
`ifdef IMM_RANGE_CHECK_EN
        enc_ok = fits_signed(in_imm, 13) && !in_imm[0];
`endif
      end
      OP_JAL: begin
        enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
`ifdef IMM_RANGE_CHECK_EN
        enc_ok = fits_signed(in_imm, 21) && !in_imm[0];
`endif
      end
      OP_LUI, OP_AUIPC: begin
        enc_word = {in_imm[31:12], in_rd, in_opcode};
`ifdef IMM_RANGE_CHECK_EN
        enc_ok = (in_imm[11:0] == 12'd0);
`endif
      end
      OP_REG: begin
        enc_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
      end
      default: begin
        enc_ok = 1'b0;
      end
    endcase
  end

  // Next-state, datapath and status logic.
  always_comb begin : next_state
    state_d     = state_q;
    remaining_d = remaining_q;
    addr_ptr_d  = addr_ptr_q;
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_addr_d  = out_addr_q;
    err_pulse_d = 1'b0;
    err_count_d = err_count_q;

    // A completed write empties the output register unless refilled below.
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    // Rejected requests still consume a job slot but do not advance the address.
    if (accept) begin
      remaining_d = remaining_q - CNT_W'(1);
      if (enc_ok) begin
        out_valid_d = 1'b1;
        out_instr_d = enc_word;
        out_addr_d  = addr_ptr_q;
        addr_ptr_d  = addr_ptr_q + ADDR_W'(4);
      end else begin
        err_pulse_d = 1'b1;
        if (err_count_q != '1) begin
          err_count_d = err_count_q + ERR_W'(1);
        end
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_ptr_d  = base_addr;
          remaining_d = count;
          state_d     = (count == CNT_W'(0)) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        if (accept && (remaining_q == CNT_W'(1))) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!out_valid_q) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      addr_ptr_q  <= '0;
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_addr_q  <= '0;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      addr_ptr_q  <= addr_ptr_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_addr_q  <= out_addr_d;
      err_pulse_q <= err_pulse_d;
      err_count_q <= err_count_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_instr = out_instr_q;
  assign out_addr  = out_addr_q;
  assign err_pulse = err_pulse_q;
  assign err_count = err_count_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_instr_encoder.sv
// -----------------------------------------------------------------------------
// tb_instr_encoder
//   Randomized and directed stimulus for instr_encoder. A behavioural model
//   (output slot, address pointer, remaining count, reject counter) is kept in
//   the bench and compared against the DUT on every falling clock edge.
//   Honours IMM_RANGE_CHECK_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_instr_encoder;

  typedef struct {
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
  } req_t;

  localparam logic [6:0] VOPS [9] = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63,
                                      7'h6f, 7'h37, 7'h17, 7'h33};

  logic        clk, rst, start;
  logic [31:0] base_addr;
  logic [15:0] count;
  logic        in_valid, in_ready;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        out_valid, out_ready;
  logic [31:0] out_instr, out_addr;
  logic        err_pulse;
  logic [7:0]  err_count;
  logic        busy, done;

  instr_encoder dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .count(count),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3),
    .in_funct7(in_funct7), .in_imm(in_imm), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr),
    .err_pulse(err_pulse), .err_count(err_count), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference encoder: plain shifts/masks from the format tables.
  function automatic void m_encode(input req_t r, output bit ok, output logic [31:0] w);
    logic [31:0] u;
`ifdef IMM_RANGE_CHECK_EN
    int s;
    s = int'($signed(r.imm));
`endif
    u  = r.imm;
    ok = 1'b1;
    w  = 32'd0;
    case (r.op)
      7'h13, 7'h03, 7'h67: begin
        w = ((u & 32'hfff) << 20) | (32'(r.rs1) << 15) | (32'(r.f3) << 12) |
            (32'(r.rd) << 7) | 32'(r.op);
`ifdef IMM_RANGE_CHECK_EN
        ok = (s >= -2048) && (s <= 2047);
`endif
      end
      7'h23: begin
        w = (((u >> 5) & 32'h7f) << 25) | (32'(r.rs2) << 20) | (32'(r.rs1) << 15) |
            (32'(r.f3) << 12) | ((u & 32'h1f) << 7) | 32'(r.op);
`ifdef IMM_RANGE_CHECK_EN
        ok = (s >= -2048) && (s <= 2047);
`endif
      end
      7'h63: begin
        w = (((u >> 12) & 32'h1) << 31) | (((u >> 5) & 32'h3f) << 25) |
            (32'(r.rs2) << 20) | (32'(r.rs1) << 15) | (32'(r.f3) << 12) |
            (((u >> 1) & 32'hf) << 8) | (((u >> 11) & 32'h1) << 7) | 32'(r.op);
`ifdef IMM_RANGE_CHECK_EN
        ok = (s >= -4096) && (s <= 4094) && ((u & 32'h1) == 0);
`endif
      end
      7'h6f: begin
        w = (((u >> 20) & 32'h1) << 31) | (((u >> 1) & 32'h3ff) << 21) |
            (((u >> 11) & 32'h1) << 20) | (((u >> 12) & 32'hff) << 12) |
            (32'(r.rd) << 7) | 32'(r.op);
`ifdef IMM_RANGE_CHECK_EN
        ok = (s >= -1048576) && (s <= 1048574) && ((u & 32'h1) == 0);
`endif
      end
      7'h37, 7'h17: begin
        w = (u & 32'hfffff000) | (32'(r.rd) << 7) | 32'(r.op);
`ifdef IMM_RANGE_CHECK_EN
        ok = ((u & 32'hfff) == 0);
`endif
      end
      7'h33: begin
        w = (32'(r.f7) << 25) | (32'(r.rs2) << 20) | (32'(r.rs1) << 15) |
            (32'(r.f3) << 12) | (32'(r.rd) << 7) | 32'(r.op);
      end
      default: ok = 1'b0;
    endcase
  endfunction

  function automatic bit is_known(input logic [6:0] op);
    foreach (VOPS[i]) if (VOPS[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  function automatic req_t mk(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [2:0] f3, input logic [31:0] imm);
    req_t r;
    r.op = op; r.rd = rd; r.rs1 = rs1; r.rs2 = rs2; r.f3 = f3; r.f7 = 7'd0; r.imm = imm;
    return r;
  endfunction

  function automatic req_t gen_req(input bit inval);
    req_t r;
    r.rd  = 5'($urandom); r.rs1 = 5'($urandom); r.rs2 = 5'($urandom);
    r.f3  = 3'($urandom); r.f7  = 7'($urandom);
    if (inval || ($urandom_range(0, 9) == 0)) begin
      r.op = 7'($urandom);
      while (is_known(r.op)) r.op = 7'($urandom);
    end else begin
      r.op = VOPS[$urandom_range(0, 8)];
    end
    if ($urandom_range(0, 7) == 0) r.imm = $urandom;
    else case (r.op)
      7'h63:        r.imm = 32'((int'($urandom_range(0, 4095)) - 2048) * 2);
      7'h6f:        r.imm = 32'((int'($urandom_range(0, 1048575)) - 524288) * 2);
      7'h37, 7'h17: r.imm = $urandom & 32'hfffff000;
      default:      r.imm = 32'(int'($urandom_range(0, 4095)) - 2048);
    endcase
    return r;
  endfunction

  // ---------------- behavioural model + per-cycle compare ----------------
  int          m_rem = 0;
  bit          exp_ov = 0, exp_err = 0, job_active = 0, hs_seen = 0, prev_done = 0;
  logic [31:0] exp_instr = 0, exp_addr = 0, m_ptr = 0;
  int          m_errcnt = 0, done_cnt = 0, err_seen = 0, cyc_n = 0;
  logic [31:0] got_instr [$];
  logic [31:0] got_addr  [$];
  int          got_cyc   [$];

  always @(negedge clk) begin
    req_t cur;
    bit ok, hs;
    logic [31:0] w;
    cyc_n++;
    if (rst) begin
      m_rem = 0; exp_ov = 0; exp_err = 0; m_errcnt = 0; job_active = 0;
      hs_seen = 0; prev_done = 0;
    end else begin
      chk("in_ready", 32'(in_ready), 32'((m_rem > 0) && (!exp_ov || out_ready)));
      chk("busy", 32'(busy), 32'(job_active));
      chk("out_valid", 32'(out_valid), 32'(exp_ov));
      if (exp_ov) begin
        chk("out_instr", out_instr, exp_instr);
        chk("out_addr", out_addr, exp_addr);
      end
      chk("err_pulse", 32'(err_pulse), 32'(exp_err));
      chk("err_count", 32'(err_count), 32'(m_errcnt));
      if (prev_done) chk("done_one_cycle", 32'(done), 32'd0);
      if (done) begin
        chk("done_after_drain", 32'((m_rem == 0) && !exp_ov), 32'd1);
        done_cnt++;
      end
      if (err_pulse) err_seen++;
      prev_done = done;

      hs = in_valid && in_ready;
      if (out_valid && out_ready) begin
        got_instr.push_back(out_instr); got_addr.push_back(out_addr); got_cyc.push_back(cyc_n);
      end
      exp_err = 0;
      if (exp_ov && out_ready) exp_ov = 0;
      if (hs) begin
        cur.op = in_opcode; cur.rd = in_rd; cur.rs1 = in_rs1; cur.rs2 = in_rs2;
        cur.f3 = in_funct3; cur.f7 = in_funct7; cur.imm = in_imm;
        m_encode(cur, ok, w);
        if (m_rem > 0) m_rem--;
        if (ok) begin
          exp_ov = 1; exp_instr = w; exp_addr = m_ptr; m_ptr = m_ptr + 32'd4;
        end else begin
          exp_err = 1;
          if (m_errcnt < 255) m_errcnt++;
        end
      end
      if (start && !job_active) begin
        job_active = 1; m_rem = int'(count); m_ptr = base_addr;
      end
      if (done) job_active = 0;
      hs_seen = hs;
    end
  end

  // ---------------- stimulus helpers ----------------
  req_t req_q [$];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive_req(input req_t r);
    in_opcode = r.op; in_rd = r.rd; in_rs1 = r.rs1; in_rs2 = r.rs2;
    in_funct3 = r.f3; in_funct7 = r.f7; in_imm = r.imm;
  endtask

  task automatic start_job(input logic [31:0] base, input logic [15:0] cnt);
    start = 1'b1; base_addr = base; count = cnt;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input bit rnd);
    int n;
    n = 0;
    in_valid = 1'b0;
    while ((done_cnt == d0) && (n < 300)) begin
      out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      tick();
      n++;
    end
    chk("job_done_seen", 32'(done_cnt - d0), 32'd1);
  endtask

  task automatic run_job(input logic [31:0] base, input int cnt, input bit rnd,
                         input bit inval, input bit mid_start);
    req_t cur;
    bit have;
    int sent, n, d0;
    d0 = done_cnt; have = 0; sent = 0; n = 0;
    start_job(base, 16'(cnt));
    while ((sent < cnt) && (n < 20 * cnt + 50)) begin
      if (!have) begin
        if (req_q.size() > 0) cur = req_q.pop_front();
        else cur = gen_req(inval);
        have = 1;
      end
      drive_req(cur);
      in_valid  = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (mid_start && (n == 2)) begin
        start = 1'b1; base_addr = 32'hDEAD_0000; count = 16'd3;
      end
      @(posedge clk);
      if (hs_seen) begin sent++; have = 0; end
      #1;
      start = 1'b0;
      n++;
    end
    wait_done(d0, rnd);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_addr", out_addr, 32'd0);
    chk("rst_err_pulse", 32'(err_pulse), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    bit ok;
    logic [31:0] w;
    int d0, e0;
    req_t addi, sw, jal, lui;

    rst = 1'b1; start = 1'b0; base_addr = 0; count = 0; in_valid = 1'b0; out_ready = 1'b1;
    drive_req(mk(7'h0, 5'd0, 5'd0, 5'd0, 3'd0, 32'd0));
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs();
    rst = 1'b0;
    tick();

    // Pin the reference encoder to hand-computed words.
    addi = mk(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5);
    sw   = mk(7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 32'd8);
    jal  = mk(7'h6f, 5'd1, 5'd0, 5'd0, 3'd0, 32'd8);
    lui  = mk(7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 32'h12345000);
    m_encode(addi, ok, w); chk("model_addi", w, 32'h00500093);
    m_encode(sw, ok, w);   chk("model_sw", w, 32'h0020A423);
    m_encode(jal, ok, w);  chk("model_jal", w, 32'h008000EF);
    m_encode(lui, ok, w);  chk("model_lui", w, 32'h123452B7);

    // Single addi job.
    got_instr.delete(); got_addr.delete(); got_cyc.delete();
    req_q.push_back(addi);
    run_job(32'h100, 1, 0, 0, 0);
    chk("addi_words", 32'(got_instr.size()), 32'd1);
    if (got_instr.size() == 1) begin
      chk("addi_instr", got_instr[0], 32'h00500093);
      chk("addi_addr", got_addr[0], 32'h100);
    end

    // Back-to-back sw, jal, lui.
    got_instr.delete(); got_addr.delete(); got_cyc.delete();
    req_q.push_back(sw); req_q.push_back(jal); req_q.push_back(lui);
    run_job(32'h400, 3, 0, 0, 0);
    chk("b2b_words", 32'(got_instr.size()), 32'd3);
    if (got_instr.size() == 3) begin
      chk("b2b_instr0", got_instr[0], 32'h0020A423);
      chk("b2b_instr1", got_instr[1], 32'h008000EF);
      chk("b2b_instr2", got_instr[2], 32'h123452B7);
      chk("b2b_addr0", got_addr[0], 32'h400);
      chk("b2b_addr1", got_addr[1], 32'h404);
      chk("b2b_addr2", got_addr[2], 32'h408);
      chk("b2b_gap01", 32'(got_cyc[1] - got_cyc[0]), 32'd1);
      chk("b2b_gap12", 32'(got_cyc[2] - got_cyc[1]), 32'd1);
    end

    // Out-of-range immediate followed by a valid addi.
    got_instr.delete(); got_addr.delete(); got_cyc.delete();
    e0 = err_seen;
    req_q.push_back(mk(7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 32'd4096));
    req_q.push_back(addi);
    run_job(32'h500, 2, 0, 0, 0);
`ifdef IMM_RANGE_CHECK_EN
    chk("range_err_pulses", 32'(err_seen - e0), 32'd1);
    chk("range_err_count", 32'(err_count), 32'd1);
    chk("range_words", 32'(got_instr.size()), 32'd1);
    if (got_instr.size() == 1) begin
      chk("range_instr", got_instr[0], 32'h00500093);
      chk("range_addr", got_addr[0], 32'h500);
    end
`else
    chk("trunc_err_pulses", 32'(err_seen - e0), 32'd0);
    chk("trunc_words", 32'(got_instr.size()), 32'd2);
    if (got_instr.size() == 2) begin
      chk("trunc_instr0", got_instr[0], 32'h00000113);
      chk("trunc_addr1", got_addr[1], 32'h504);
    end
`endif

    // Backpressure: word held for 5 cycles, then exactly one transfer.
    got_instr.delete(); got_addr.delete(); got_cyc.delete();
    d0 = done_cnt;
    start_job(32'h600, 16'd2);
    drive_req(addi); in_valid = 1'b1; out_ready = 1'b0;
    tick();
    drive_req(sw);
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_instr", out_instr, 32'h00500093);
      chk("hold_addr", out_addr, 32'h600);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    chk("hold_no_xfer", 32'(got_instr.size()), 32'd0);
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    chk("release_one_xfer", 32'(got_instr.size()), 32'd1);
    tick(); tick();
    chk("release_still_one", 32'(got_instr.size()), 32'd1);
    wait_done(d0, 0);
    chk("release_total", 32'(got_instr.size()), 32'd2);

    // Empty job.
    got_instr.delete(); got_addr.delete(); got_cyc.delete();
    d0 = done_cnt;
    start_job(32'h700, 16'd0);
    tick(); tick();
    chk("empty_done", 32'(done_cnt - d0), 32'd1);
    chk("empty_words", 32'(got_instr.size()), 32'd0);

    // Randomized jobs (address wrap, stray start mid-job).
    run_job(32'hFFFF_FFF8, 12, 1, 0, 0);
    for (int k = 0; k < 5; k++) begin
      run_job($urandom & 32'hFFFF_FFFC, $urandom_range(10, 40), 1, 0, k == 1);
    end

    // Saturating reject counter.
    run_job(32'h900, 300, 0, 1, 0);
    chk("err_saturated", 32'(err_count), 32'd255);

    // Reset mid-LOAD with a word pending.
    d0 = done_cnt;
    start_job(32'h800, 16'd10);
    drive_req(addi); in_valid = 1'b1; out_ready = 1'b0;
    tick(); tick();
    #2 rst = 1'b1;
    #1 chk_reset_outputs();
    in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    out_ready = 1'b1;
    repeat (4) tick();
    chk("rst_no_done", 32'(done_cnt - d0), 32'd0);
    chk("rst_no_word", 32'(out_valid), 32'd0);

    // Post-reset job.
    run_job(32'h1000, 20, 1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
